// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with occupancy count, thresholds, sticky error flags
// and optional FWFT read mode. Define SFIFO_PEAK_EN to add the peak_count high-watermark.
module sfifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
`ifdef SFIFO_PEAK_EN
  output logic [$clog2(DEPTH):0]     peak_count,
`endif
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sfifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sfifo_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("sfifo_param: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow, r_underflow;
  logic              w_wr_acc, w_rd_acc;

  // Status flags decode the registered count only; there is no same-cycle bypass.
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
      if (wr_en && full)  r_overflow  <= 1'b1;
      if (rd_en && empty) r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!srst && w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = r_mem[r_rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;
      always_ff @(posedge clk) begin
        if (srst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
        end
      end
      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

`ifdef SFIFO_PEAK_EN
  logic [CW-1:0] r_peak;
  always_ff @(posedge clk) begin
    if (srst)                  r_peak <= '0;
    else if (r_count > r_peak) r_peak <= r_count;
  end
  assign peak_count = r_peak;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Bench for sfifo_param: standard and FWFT instances share stimulus and are checked
// against a queue-based reference model, plus a vector table and directed sequences.
module tb_sfifo_param;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          s_full, s_af, s_empty, s_ae, s_rv, s_ovf, s_udf;
  logic [DW-1:0] s_rd;
  logic [4:0]    s_cnt;
  logic          f_full, f_af, f_empty, f_ae, f_rv, f_ovf, f_udf;
  logic [DW-1:0] f_rd;
  logic [4:0]    f_cnt;
`ifdef SFIFO_PEAK_EN
  logic [4:0]    s_peak, f_peak;
`endif

  sfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .srst(srst), .wr_en(wr_en), .wr_data(wr_data), .full(s_full),
    .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd), .rd_valid(s_rv), .empty(s_empty),
    .almost_empty(s_ae), .count(s_cnt),
`ifdef SFIFO_PEAK_EN
    .peak_count(s_peak),
`endif
    .overflow(s_ovf), .underflow(s_udf));

  sfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .srst(srst), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
    .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd), .rd_valid(f_rv), .empty(f_empty),
    .almost_empty(f_ae), .count(f_cnt),
`ifdef SFIFO_PEAK_EN
    .peak_count(f_peak),
`endif
    .overflow(f_ovf), .underflow(f_udf));

  int total = 0;
  int bad = 0;

  // Reference model: the FIFO contents as a queue plus the sticky/registered outputs.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_rd;
  int            m_peak;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std.count", 32'(s_cnt), 32'(n));
    chk("std.empty", 32'(s_empty), 32'(n == 0));
    chk("std.full", 32'(s_full), 32'(n == DEPTH));
    chk("std.almost_full", 32'(s_af), 32'(n >= AF));
    chk("std.almost_empty", 32'(s_ae), 32'(n <= AE));
    chk("std.overflow", 32'(s_ovf), 32'(m_ovf));
    chk("std.underflow", 32'(s_udf), 32'(m_udf));
    chk("std.rd_valid", 32'(s_rv), 32'(m_rv));
    chk("std.rd_data", 32'(s_rd), 32'(m_rd));
    chk("fwft.count", 32'(f_cnt), 32'(n));
    chk("fwft.rd_valid", 32'(f_rv), 32'(n != 0));
    if (n != 0) chk("fwft.rd_data", 32'(f_rd), 32'(q[0]));
    chk("fwft.flags", {28'd0, f_full, f_empty, f_ovf, f_udf},
        {28'd0, 1'(n == DEPTH), 1'(n == 0), m_ovf, m_udf});
`ifdef SFIFO_PEAK_EN
    chk("std.peak_count", 32'(s_peak), 32'(m_peak));
    chk("fwft.peak_count", 32'(f_peak), 32'(m_peak));
`endif
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge occupancy.
  task automatic cyc(input bit rst, input bit w, input bit r, input logic [DW-1:0] d);
    int n;
    srst = rst; wr_en = w; rd_en = r; wr_data = d;
    n = q.size();
    if (rst) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0; m_peak = 0;
    end else begin
      if (n > m_peak) m_peak = n;
      if (w && n == DEPTH) m_ovf = 1;
      if (r && n == 0) m_udf = 1;
      m_rv = r && (n > 0);
      if (m_rv) m_rd = q.pop_front();
      if (w && n < DEPTH) q.push_back(d);
    end
    @(posedge clk);
    #1;
    srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_all();
  endtask

  typedef struct {
    bit            w;
    bit            r;
    logic [DW-1:0] d;
    int            cnt;
    bit            rv;
    logic [DW-1:0] rdat;
    bit            udf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 0, 8'h11, 1, 0, 8'h00, 0};
    tbl[1] = '{1, 0, 8'h22, 2, 0, 8'h00, 0};
    tbl[2] = '{0, 1, 8'h00, 1, 1, 8'h11, 0};
    tbl[3] = '{1, 1, 8'h33, 1, 1, 8'h22, 0};
    tbl[4] = '{0, 1, 8'h00, 0, 1, 8'h33, 0};
    tbl[5] = '{0, 0, 8'h00, 0, 0, 8'h33, 0};
    tbl[6] = '{1, 1, 8'h44, 1, 0, 8'h33, 1};
    tbl[7] = '{0, 1, 8'h00, 0, 1, 8'h44, 1};

    // Reset / idle
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, 8'hFF);
    cyc(0, 0, 0, '0);
    chk("reset.empty", 32'(s_empty), 1);
    chk("reset.almost_empty", 32'(s_ae), 1);
    chk("reset.full", 32'(s_full), 0);
    chk("reset.count", 32'(s_cnt), 0);
    chk("reset.rd_valid", 32'(s_rv), 0);
    chk("reset.ovf_udf", {30'd0, s_ovf, s_udf}, 0);

    // Vector table (standard mode outputs)
    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d.count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.rd_valid", i), 32'(s_rv), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d.rd_data", i), 32'(s_rd), 32'(tbl[i].rdat));
      chk($sformatf("tbl%0d.underflow", i), 32'(s_udf), 32'(tbl[i].udf));
    end

    // Fill and drain, then error flags
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 8'(i));
      if (i == 12) chk("fill.af_after13", 32'(s_af), 0);
      if (i == 13) chk("fill.af_after14", 32'(s_af), 1);
      if (i == 14) chk("fill.full_after15", 32'(s_full), 0);
    end
    chk("fill.full", 32'(s_full), 1);
    chk("fill.count", 32'(s_cnt), 16);
    cyc(0, 1, 0, 8'hEE);
    chk("ovf.set", 32'(s_ovf), 1);
    chk("ovf.count", 32'(s_cnt), 16);
    cyc(0, 1, 1, 8'hDD);
    chk("ovf.wr_while_full_rd", 32'(s_cnt), 15);
    chk("ovf.first_word", 32'(s_rd), 8'h00);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, '0);
      chk($sformatf("drain%0d.data", i), 32'(s_rd), 32'(i));
    end
    chk("drain.empty", 32'(s_empty), 1);
    cyc(0, 0, 1, '0);
    chk("udf.set", 32'(s_udf), 1);
    chk("udf.rd_valid", 32'(s_rv), 0);
    repeat (3) cyc(0, 0, 0, '0);
    chk("sticky.both", {30'd0, s_ovf, s_udf}, 3);

    // Wrap with simultaneous access at count 3
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h80 + i));
    for (int i = 3; i < 43; i++) begin
      cyc(0, 1, 1, 8'(8'h80 + i));
      chk("wrap.count", 32'(s_cnt), 3);
      chk("wrap.data", 32'(s_rd), 32'(8'(8'h80 + i - 3)));
    end

    // FWFT head visibility
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, 8'hA5);
    chk("fwft.rv_no_rden", 32'(f_rv), 1);
    chk("fwft.head", 32'(f_rd), 8'hA5);
    cyc(0, 0, 1, '0);
    chk("fwft.empty_after_pop", 32'(f_empty), 1);
    chk("fwft.rv_after_pop", 32'(f_rv), 0);

`ifdef SFIFO_PEAK_EN
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'(i));
    cyc(0, 0, 0, '0);
    chk("peak.after_writes", 32'(s_peak), 10);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, '0);
    chk("peak.after_reads", 32'(s_peak), 10);
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'(i));
    cyc(1, 1, 0, 8'h77);
    chk("peak.rst_count", 32'(s_cnt), 0);
    chk("peak.rst_empty", 32'(s_empty), 1);
    chk("peak.rst_peak", 32'(s_peak), 0);
`endif

    // Randomised traffic with occasional mid-stream reset
    for (int i = 0; i < 2000; i++) begin
      int mode;
      mode = (i / 200) % 3;
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 3 : 5)),
          $urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 7 : 5)),
          8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
